control_sequencer: RTL and testbench

- Hardwired Moore control unit for the Mini SRC datapath; it drives every strobe the datapath consumes.
- Runs fetch (T0-T2), then the opcode-specific execute steps (T3-T7). It reads the IR and CON back from the datapath.
- Replaces hand-written state sequencing in testbenches; sits directly upstream of datapath.

---
 rtl/cpu_ctrl_pkg.sv | 59 +++++
 rtl/ctrl_wait_counter.sv | 32 +++
 rtl/control_sequencer.sv | 157 +++++++++++++++
 tb/tb_control_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the Mini SRC hardwired control unit:
//   - state_t    : sequencer states (RESET, T0..T7, HALT)
//   - OP_*       : 5-bit opcode values found in IR[31:27]
//   - *_MSB/_LSB : IR field positions (opcode, ra, rb, rc)
//   - last_step(): the final execute state for a given opcode
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    RESET,
    T0, T1, T2, T3, T4, T5, T6, T7,
    HALT
  } state_t;

  // IR field slices
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // Opcodes
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Final execute state of each instruction. Anything not listed behaves
  // as a single-step instruction (nop, jr, in, out, mfhi, mflo, halt).
  function automatic state_t last_step(input logic [4:0] opc);
    state_t s;
    case (opc)
      OP_LD, OP_ST:                         s = T7;
      OP_BR:                                s = T6;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI:             s = T5;
      default:                              s = T3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// ctrl_wait_counter
// Down-counter that stretches memory-access steps by MEM_WAIT cycles.
//   Clock   : system clock, rising edge
//   Reset_n : asynchronous active-low reset, clears the count
//   load    : reload the count with MEM_WAIT (asserted on every state change)
//   done    : count has reached zero; a memory step may advance
module ctrl_wait_counter #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic load,
  output logic done
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

  logic [2:0] count_reg;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count_reg <= 3'd0;
    end else if (load) begin
      count_reg <= WAIT_INIT;
    end else if (count_reg != 3'd0) begin
      count_reg <= count_reg - 3'd1;
    end
  end

  assign done = (count_reg == 3'd0);

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired Moore control unit for the Mini SRC datapath. Runs the fetch
// steps T0-T2, then the opcode-specific execute steps T3-T7, and drives
// every datapath strobe combinationally from the current state and opcode.
//   Clock, Reset_n   : clock (rising edge) and async active-low reset
//   Stop             : halt at the next instruction boundary
//   IR, CON          : instruction register and branch condition from datapath
//   Run              : high while sequencing (not in RESET or HALT)
//   *in              : register load enables
//   *out             : bus drive selects (at most one high per cycle)
//   Gra Grb Grc Rin Rout : register-file select/enable
//   Read write IncPC : memory read, memory write, PC increment
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned OPC_W    = 5
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Stop,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        Run,
  output logic        PCin, MDRin, MARin, IRin, Yin, Zin, HIin, LOin, CONin, OUTPORTin,
  output logic        PCout, MDRout, ZHIout, ZLOout, HIout, LOout, INPORTout, Cout, BAout,
  output logic        Gra, Grb, Grc, Rin, Rout,
  output logic        Read, write, IncPC
);

  state_t state_reg, state_next;

  logic [OPC_W-1:0] opcode;
  logic             wait_done;
  logic             mem_step;
  logic             exec_step;
  logic             unused_ir;

  assign opcode    = IR[OPC_MSB -: OPC_W];
  // Register fields are consumed by the datapath, not by the sequencer.
  assign unused_ir = ^IR[OPC_LSB-1:0];

  // Steps that touch memory hold for 1+MEM_WAIT cycles.
  assign mem_step  = (state_reg == T1)
                   || (state_reg == T6 && opcode == OP_LD)
                   || (state_reg == T7 && opcode == OP_ST);
  assign exec_step = (state_reg == T3) || (state_reg == T4) || (state_reg == T5)
                   || (state_reg == T6) || (state_reg == T7);

  ctrl_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .load    (state_next != state_reg),
    .done    (wait_done)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_reg <= RESET;
    else          state_reg <= state_next;
  end

  assign Run = (state_reg != RESET) && (state_reg != HALT);

  always_comb begin
    state_next = state_reg;
    {PCin, MDRin, MARin, IRin, Yin, Zin, HIin, LOin, CONin, OUTPORTin} = '0;
    {PCout, MDRout, ZHIout, ZLOout, HIout, LOout, INPORTout, Cout, BAout} = '0;
    {Gra, Grb, Grc, Rin, Rout} = '0;
    {Read, write, IncPC} = '0;

    case (state_reg)
      RESET: state_next = T0;
      T0: begin
        PCout = 1'b1; MARin = 1'b1;
        state_next = T1;
      end
      T1: begin
        Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; IncPC = 1'b1;
        state_next = T2;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_next = T3;
      end
      T3: begin
        state_next = T4;
        case (opcode)
          OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_IN:   begin INPORTout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1; end
          OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        state_next = T5;
        case (opcode)
          OP_LD, OP_LDI, OP_ST,
          OP_ADDI, OP_ANDI, OP_ORI: begin Cout = 1'b1; Zin = 1'b1; end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          OP_BR:   begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        state_next = T6;
        case (opcode)
          OP_LD, OP_ST: begin ZLOout = 1'b1; MARin = 1'b1; end
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_BR:   begin Cout = 1'b1; Zin = 1'b1; end
          default: ;
        endcase
      end
      T6: begin
        state_next = T7;
        case (opcode)
          OP_LD:   begin Read = 1'b1; MDRin = 1'b1; end
          OP_ST:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          // Branch step is always visited; only the PC load depends on CON.
          OP_BR:   begin ZLOout = CON; PCin = CON; end
          default: ;
        endcase
      end
      T7: begin
        state_next = T0;
        case (opcode)
          OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST:   write = 1'b1;
          default: ;
        endcase
      end
      HALT:    state_next = HALT;
      default: state_next = RESET;
    endcase

    // Instruction boundary: return to fetch, or park if halt/Stop requested.
    if (exec_step && state_reg == last_step(opcode)) begin
      state_next = (Stop || opcode == OP_HALT) ? HALT : T0;
    end
    // Memory steps hold until the wait counter drains.
    if (mem_step && !wait_done) begin
      state_next = state_reg;
    end
  end

  a_one_bus_driver: assert property (@(posedge Clock) disable iff (!Reset_n)
    $countones({PCout, MDRout, ZHIout, ZLOout, HIout, LOout, INPORTout, Cout, BAout, Rout}) <= 1);
  a_read_write_excl: assert property (@(posedge Clock) disable iff (!Reset_n)
    !(Read && write));

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  // Strobe vector bit order
  localparam logic [26:0] S_PCIN   = 27'd1 << 0;
  localparam logic [26:0] S_MDRIN  = 27'd1 << 1;
  localparam logic [26:0] S_MARIN  = 27'd1 << 2;
  localparam logic [26:0] S_IRIN   = 27'd1 << 3;
  localparam logic [26:0] S_YIN    = 27'd1 << 4;
  localparam logic [26:0] S_ZIN    = 27'd1 << 5;
  localparam logic [26:0] S_CONIN  = 27'd1 << 8;
  localparam logic [26:0] S_PCOUT  = 27'd1 << 10;
  localparam logic [26:0] S_MDROUT = 27'd1 << 11;
  localparam logic [26:0] S_ZLOOUT = 27'd1 << 13;
  localparam logic [26:0] S_HIOUT  = 27'd1 << 14;
  localparam logic [26:0] S_COUT   = 27'd1 << 17;
  localparam logic [26:0] S_BAOUT  = 27'd1 << 18;
  localparam logic [26:0] S_GRA    = 27'd1 << 19;
  localparam logic [26:0] S_GRB    = 27'd1 << 20;
  localparam logic [26:0] S_GRC    = 27'd1 << 21;
  localparam logic [26:0] S_RIN    = 27'd1 << 22;
  localparam logic [26:0] S_ROUT   = 27'd1 << 23;
  localparam logic [26:0] S_READ   = 27'd1 << 24;
  localparam logic [26:0] S_WRITE  = 27'd1 << 25;
  localparam logic [26:0] S_INCPC  = 27'd1 << 26;
  localparam logic [26:0] BUS_MASK = 27'h087FC00;   // bits 10..18 and 23

  localparam logic [26:0] E_T0 = S_PCOUT | S_MARIN;
  localparam logic [26:0] E_T1 = S_READ | S_MDRIN | S_PCIN | S_INCPC;
  localparam logic [26:0] E_T2 = S_MDROUT | S_IRIN;

  logic        Clock, Reset_n, Stop, CON;
  logic [31:0] IR;
  logic [26:0] o0, o2;
  logic        run0, run2;
  logic        sel;
  int          total = 0;
  int          bad = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  control_sequencer #(.MEM_WAIT(0), .OPC_W(5)) dut0 (
    .Clock(Clock), .Reset_n(Reset_n), .Stop(Stop), .IR(IR), .CON(CON), .Run(run0),
    .PCin(o0[0]), .MDRin(o0[1]), .MARin(o0[2]), .IRin(o0[3]), .Yin(o0[4]), .Zin(o0[5]),
    .HIin(o0[6]), .LOin(o0[7]), .CONin(o0[8]), .OUTPORTin(o0[9]),
    .PCout(o0[10]), .MDRout(o0[11]), .ZHIout(o0[12]), .ZLOout(o0[13]), .HIout(o0[14]),
    .LOout(o0[15]), .INPORTout(o0[16]), .Cout(o0[17]), .BAout(o0[18]),
    .Gra(o0[19]), .Grb(o0[20]), .Grc(o0[21]), .Rin(o0[22]), .Rout(o0[23]),
    .Read(o0[24]), .write(o0[25]), .IncPC(o0[26])
  );

  control_sequencer #(.MEM_WAIT(2), .OPC_W(5)) dut2 (
    .Clock(Clock), .Reset_n(Reset_n), .Stop(Stop), .IR(IR), .CON(CON), .Run(run2),
    .PCin(o2[0]), .MDRin(o2[1]), .MARin(o2[2]), .IRin(o2[3]), .Yin(o2[4]), .Zin(o2[5]),
    .HIin(o2[6]), .LOin(o2[7]), .CONin(o2[8]), .OUTPORTin(o2[9]),
    .PCout(o2[10]), .MDRout(o2[11]), .ZHIout(o2[12]), .ZLOout(o2[13]), .HIout(o2[14]),
    .LOout(o2[15]), .INPORTout(o2[16]), .Cout(o2[17]), .BAout(o2[18]),
    .Gra(o2[19]), .Grb(o2[20]), .Grc(o2[21]), .Rin(o2[22]), .Rout(o2[23]),
    .Read(o2[24]), .write(o2[25]), .IncPC(o2[26])
  );

  // Exclusion checks on both instances every cycle
  always @(negedge Clock) begin
    if (Reset_n) begin
      total++;
      assert ($countones(o0 & BUS_MASK) <= 1 && $countones(o2 & BUS_MASK) <= 1) else begin
        bad++;
        $error("FAIL bus_excl got=%h/%h want at most one driver", o0 & BUS_MASK, o2 & BUS_MASK);
      end
      total++;
      assert (!(o0[24] && o0[25]) && !(o2[24] && o2[25])) else begin
        bad++;
        $error("FAIL rd_wr_excl got=%b%b/%b%b want not both", o0[24], o0[25], o2[24], o2[25]);
      end
    end
  end

  task automatic check(input string tag, input logic [26:0] exp_s, input logic exp_run);
    logic [26:0] s;
    logic        r;
    s = sel ? o2 : o0;
    r = sel ? run2 : run0;
    $display("t=%0t %s strobes=%h run=%b", $time, tag, s, r);
    total++;
    assert (s === exp_s) else begin
      bad++;
      $error("FAIL %s strobes got=%h want=%h", tag, s, exp_s);
    end
    total++;
    assert (r === exp_run) else begin
      bad++;
      $error("FAIL %s run got=%b want=%b", tag, r, exp_run);
    end
  endtask

  task automatic cyc(input string tag, input logic [26:0] exp_s);
    @(negedge Clock);
    check(tag, exp_s, 1'b1);
  endtask

  task automatic reset_seq(input string tag);
    @(negedge Clock);
    Reset_n = 1'b0;
    @(negedge Clock);
    check({tag, "_rst"}, 27'd0, 1'b0);
    Reset_n = 1'b1;
    cyc({tag, "_T0"}, E_T0);
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_T1"}, E_T1);
    cyc({tag, "_T2"}, E_T2);
  endtask

  initial begin
    Reset_n = 1'b0; Stop = 1'b0; CON = 1'b0; sel = 1'b0;
    IR = 32'h1989_0000;

    // Reset, then abort an add in T4
    @(negedge Clock);
    @(negedge Clock);
    check("rst_init", 27'd0, 1'b0);
    Reset_n = 1'b1;
    cyc("add0_T0", E_T0);
    fetch("add0");
    cyc("add0_T3", S_GRB | S_ROUT | S_YIN);
    cyc("add0_T4", S_GRC | S_ROUT | S_ZIN);
    Reset_n = 1'b0;
    #1;
    check("rst_midT4", 27'd0, 1'b0);
    @(negedge Clock);
    check("rst_hold", 27'd0, 1'b0);
    Reset_n = 1'b1;
    cyc("post_rst_T0", E_T0);

    // mfhi R4
    IR = 32'hC200_0000;
    fetch("mfhi");
    cyc("mfhi_T3", S_HIOUT | S_GRA | S_RIN);
    cyc("mfhi_next_T0", E_T0);

    // add R3,R1,R2
    IR = 32'h1989_0000;
    fetch("add");
    cyc("add_T3", S_GRB | S_ROUT | S_YIN);
    cyc("add_T4", S_GRC | S_ROUT | S_ZIN);
    cyc("add_T5", S_ZLOOUT | S_GRA | S_RIN);
    cyc("add_next_T0", E_T0);

    // br R5, condition false then true
    for (int c = 0; c < 2; c++) begin
      IR = 32'h9A80_0000;
      CON = c[0];
      fetch("br");
      cyc("br_T3", S_GRA | S_ROUT | S_CONIN);
      cyc("br_T4", S_PCOUT | S_YIN);
      cyc("br_T5", S_COUT | S_ZIN);
      cyc(c == 0 ? "br_T6_con0" : "br_T6_con1", c == 0 ? 27'd0 : (S_ZLOOUT | S_PCIN));
      cyc("br_next_T0", E_T0);
    end
    CON = 1'b0;

    // Unlisted opcode behaves as nop
    IR = 32'hF800_0000;
    fetch("unl");
    cyc("unl_T3", 27'd0);
    cyc("unl_next_T0", E_T0);

    // ld on the MEM_WAIT=2 instance: 12 cycles
    sel = 1'b1;
    IR = 32'h0000_0000;
    reset_seq("ld");
    for (int i = 0; i < 3; i++) cyc("ld_T1", E_T1);
    cyc("ld_T2", E_T2);
    cyc("ld_T3", S_GRB | S_BAOUT | S_YIN);
    cyc("ld_T4", S_COUT | S_ZIN);
    cyc("ld_T5", S_ZLOOUT | S_MARIN);
    for (int i = 0; i < 3; i++) cyc("ld_T6", S_READ | S_MDRIN);
    cyc("ld_T7", S_MDROUT | S_GRA | S_RIN);
    cyc("ld_next_T0", E_T0);

    // halt instruction
    sel = 1'b0;
    reset_seq("halt");
    IR = 32'hD800_0000;
    fetch("halt");
    cyc("halt_T3", 27'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      check("halt_parked", 27'd0, 1'b0);
    end
    reset_seq("halt_exit");

    // Stop held from T0 is ignored until the nop's last step
    IR = 32'hD000_0000;
    Stop = 1'b1;
    fetch("stop");
    cyc("stop_T3", 27'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      check("stop_parked", 27'd0, 1'b0);
    end
    Stop = 1'b0;
    reset_seq("stop_exit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
